// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port (instruction fetch / load-store) arbiter in front of
//               a single-ported synchronous memory. LS has priority, and an
//               anti-starvation streak counter hands IF the port after
//               MAX_LS_STREAK back-to-back LS wins. Misaligned LS accesses
//               are rejected with an error ack and never reach memory.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_LS_STREAK = 3
) (
    input  logic              clk,
    input  logic              rst,
    // instruction fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    // load/store port
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_ack,
    output logic              ls_err,
    output logic [DATA_W-1:0] ls_rdata,
    // memory side
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int c_STREAK_W = (MAX_LS_STREAK < 1) ? 1 : $clog2(MAX_LS_STREAK + 1);
    localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(MAX_LS_STREAK);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_RESP   = 2'd2;
    localparam logic [1:0] c_ST_ERR    = 2'd3;

    logic [1:0]            r_state;
    logic [c_STREAK_W-1:0] r_streak;
    logic                  r_owner_ls;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic                  r_we;
    logic                  r_mem_en;
    logic                  r_mem_we;
    logic                  r_if_ack;
    logic                  r_ls_ack;
    logic                  r_ls_err;

    logic                  w_grant_ls;
    logic                  w_ls_misaligned;

    // LS wins ties unless IF has been passed over MAX_LS_STREAK times in a row
    assign w_grant_ls      = ls_req && !(if_req && (r_streak == c_STREAK_MAX));
    assign w_ls_misaligned = (ls_addr[1:0] != 2'b00);

    // Arbitration FSM; every control output is registered here so it is
    // glitch-free and aligned with the state it belongs to
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_streak   <= '0;
            r_owner_ls <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_if_ack   <= 1'b0;
            r_ls_ack   <= 1'b0;
            r_ls_err   <= 1'b0;
        end else begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            r_if_ack <= 1'b0;
            r_ls_ack <= 1'b0;
            r_ls_err <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_grant_ls) begin
                        r_owner_ls <= 1'b1;
                        r_addr     <= ls_addr;
                        r_wdata    <= ls_wdata;
                        r_we       <= ls_we;
                        if (w_ls_misaligned) begin
                            // rejected grant: error ack next cycle, streak untouched
                            r_state  <= c_ST_ERR;
                            r_ls_ack <= 1'b1;
                            r_ls_err <= 1'b1;
                        end else begin
                            r_state  <= c_ST_ACCESS;
                            r_mem_en <= 1'b1;
                            r_mem_we <= ls_we;
                            if (if_req && (r_streak != c_STREAK_MAX)) begin
                                r_streak <= r_streak + 1'b1;
                            end
                        end
                    end else if (if_req) begin
                        r_owner_ls <= 1'b0;
                        r_addr     <= if_addr;
                        r_wdata    <= '0;
                        r_we       <= 1'b0;
                        r_state    <= c_ST_ACCESS;
                        r_mem_en   <= 1'b1;
                        r_streak   <= '0;
                    end
                end
                c_ST_ACCESS: begin
                    // read data arrives during RESP, so the ack goes out then
                    r_state <= c_ST_RESP;
                    if (r_owner_ls) begin
                        r_ls_ack <= 1'b1;
                    end else begin
                        r_if_ack <= 1'b1;
                    end
                end
                c_ST_RESP: r_state <= c_ST_IDLE;
                c_ST_ERR:  r_state <= c_ST_IDLE;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_we ? r_wdata : '0;
    assign if_ack    = r_if_ack;
    assign ls_ack    = r_ls_ack;
    assign ls_err    = r_ls_err;

    // Memory read data is only valid in the RESP cycle; gate it to the owner
    assign if_rdata  = r_if_ack ? mem_rdata : '0;
    assign ls_rdata  = (r_ls_ack && !r_ls_err) ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter with a
//               scoreboard of expected acks and a small memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic        ls_ack;
    logic        ls_err;
    logic [31:0] ls_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .MAX_LS_STREAK(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_ack(if_ack),
        .if_rdata(if_rdata),
        .ls_req(ls_req),
        .ls_we(ls_we),
        .ls_addr(ls_addr),
        .ls_wdata(ls_wdata),
        .ls_ack(ls_ack),
        .ls_err(ls_err),
        .ls_rdata(ls_rdata),
        .mem_en(mem_en),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // synchronous memory model: read data valid the cycle after mem_en
    logic [31:0] mem [0:255];
    logic        pre_en = 1'b0;
    logic [7:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;
    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_data;
        if (mem_en) begin
            if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[9:2]];
        end
    end

    typedef struct {
        logic        ls;
        logic        err;
        logic        chk;
        logic [31:0] rdata;
        int          at;
    } exp_t;

    exp_t sb[$];
    logic ack_log[$];
    int   ack_cyc[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   mem_en_cnt = 0;
    bit   sb_en = 1'b1;
    bit   drop_en = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one clock; sample #1 after the edge and retire any ack against the scoreboard
    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        if (mem_en) mem_en_cnt++;
        if (if_ack || ls_ack) begin
            chk("one_ack", {31'd0, if_ack & ls_ack}, 32'd0);
            if (!sb_en) begin
                ack_log.push_back(ls_ack);
                ack_cyc.push_back(cyc);
            end else if (sb.size() == 0) begin
                chk("unexpected_ack", {30'd0, if_ack, ls_ack}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("ack_port", {31'd0, ls_ack}, {31'd0, e.ls});
                chk("ack_cycle", cyc, e.at);
                chk("ls_err", {31'd0, ls_err}, {31'd0, e.err});
                if (e.chk) chk("rdata", e.ls ? ls_rdata : if_rdata, e.rdata);
            end
            if (drop_en) begin
                if (if_ack) if_req = 1'b0;
                if (ls_ack) ls_req = 1'b0;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // requests are issued with the arbiter idle, so the grant is the next edge
    task automatic issue_if(input logic [31:0] a, input logic [31:0] exp_d);
        if_req  = 1'b1;
        if_addr = a;
        sb.push_back('{ls: 1'b0, err: 1'b0, chk: 1'b1, rdata: exp_d, at: cyc + 2});
    endtask

    task automatic issue_ls(input logic we, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] exp_d);
        logic err;
        err      = (a[1:0] != 2'b00);
        ls_req   = 1'b1;
        ls_we    = we;
        ls_addr  = a;
        ls_wdata = d;
        sb.push_back('{ls: 1'b1, err: err, chk: (!we && !err), rdata: exp_d,
                       at: err ? cyc + 1 : cyc + 2});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_if_ack"}, {31'd0, if_ack}, 32'd0);
        chk({tag, "_ls_ack"}, {31'd0, ls_ack}, 32'd0);
        chk({tag, "_ls_err"}, {31'd0, ls_err}, 32'd0);
        chk({tag, "_mem_en"}, {31'd0, mem_en}, 32'd0);
        chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_if_rdata"}, if_rdata, 32'd0);
        chk({tag, "_ls_rdata"}, ls_rdata, 32'd0);
    endtask

    initial begin
        logic exp_order [8];
        int   n_en;

        // reset and memory preload
        rst = 1'b1;
        run(2);
        chk_all_zero("reset");
        pre_en = 1'b1; pre_idx = 8'h40; pre_data = 32'hDEAD_BEEF;
        tick();
        pre_en = 1'b0;
        rst = 1'b0;
        tick();

        // IF read of 0x100
        issue_if(32'h100, 32'hDEAD_BEEF);
        tick();
        chk("if_mem_en", {31'd0, mem_en}, 32'd1);
        chk("if_mem_addr", mem_addr, 32'h100);
        chk("if_mem_we", {31'd0, mem_we}, 32'd0);
        run(3);
        chk("sb_empty_if", sb.size(), 32'd0);

        // store then load at 0x20
        issue_ls(1'b1, 32'h20, 32'h1234_5678, 32'd0);
        tick();
        chk("st_mem_en", {31'd0, mem_en}, 32'd1);
        chk("st_mem_we", {31'd0, mem_we}, 32'd1);
        chk("st_mem_addr", mem_addr, 32'h20);
        chk("st_mem_wdata", mem_wdata, 32'h1234_5678);
        run(3);
        issue_ls(1'b0, 32'h20, 32'd0, 32'h1234_5678);
        run(4);
        issue_if(32'h20, 32'h1234_5678);
        run(4);

        // misaligned LS: error ack, memory untouched
        n_en = mem_en_cnt;
        issue_ls(1'b0, 32'h22, 32'd0, 32'd0);
        run(4);
        chk("misalign_no_mem_en", mem_en_cnt, n_en);

        // LS request dropped right after grant still completes
        issue_ls(1'b0, 32'h20, 32'd0, 32'h1234_5678);
        tick();
        ls_req = 1'b0;
        run(3);
        chk("sb_empty_drop", sb.size(), 32'd0);

        // reset during an IF access: no ack follows
        if_req  = 1'b1;
        if_addr = 32'h100;
        tick();
        chk("rst_acc_mem_en", {31'd0, mem_en}, 32'd1);
        rst = 1'b1;
        tick();
        chk_all_zero("rst_access");
        rst    = 1'b0;
        if_req = 1'b0;
        run(4);

        // collision: both held high, LS x3 then IF, every 3 cycles
        sb_en   = 1'b0;
        drop_en = 1'b0;
        ls_we   = 1'b0;
        ls_addr = 32'h40;
        if_addr = 32'h44;
        ls_req  = 1'b1;
        if_req  = 1'b1;
        run(24);
        ls_req  = 1'b0;
        if_req  = 1'b0;
        run(4);
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        chk("coll_ack_count", ack_log.size(), 32'd8);
        for (int k = 0; k < 8 && k < ack_log.size(); k++) begin
            chk($sformatf("coll_owner_%0d", k), {31'd0, ack_log[k]}, {31'd0, exp_order[k]});
            if (k > 0) chk($sformatf("coll_gap_%0d", k), ack_cyc[k] - ack_cyc[k-1], 32'd3);
        end
        sb_en   = 1'b1;
        drop_en = 1'b1;

        // IF fairness does not linger: a lone IF read after collisions
        issue_if(32'h100, 32'hDEAD_BEEF);
        run(4);
        chk("sb_empty_end", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the word width.
REQ-003 SHALL have parameter MAX_LS_STREAK, default 3, meaning consecutive LS grants allowed while IF waits.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports if_req (in, 1, fetch request), if_addr (in, ADDR_W), if_ack (out, 1), if_rdata (out, DATA_W).
REQ-007 SHALL have ports ls_req (in, 1), ls_we (in, 1, 1=store), ls_addr (in, ADDR_W), ls_wdata (in, DATA_W), ls_ack (out, 1), ls_err (out, 1, misaligned), ls_rdata (out, DATA_W).
REQ-008 SHALL have ports mem_en (out, 1), mem_we (out, 1), mem_addr (out, ADDR_W), mem_wdata (out, DATA_W), and mem_rdata (in, DATA_W), which is valid the cycle after a read with mem_en=1.

Function
REQ-009 SHALL implement FSM states IDLE, ACCESS, RESP, ERR.
REQ-010 SHALL, in IDLE with any request, grant one port and latch that port's addr/we/wdata plus a grant-owner bit at the rising edge.
REQ-011 SHALL grant LS over IF when both request, unless the streak counter equals MAX_LS_STREAK and if_req=1, in which case IF wins.
REQ-012 SHALL increment the streak counter (saturating) on each LS grant made while if_req=1, and clear it on every IF grant.
REQ-013 SHALL go IDLE->ERR instead of ACCESS on an LS grant with ls_addr[1:0]!=0; ERR SHALL drive ls_ack=1 and ls_err=1 for one cycle, never assert mem_en, leave the streak counter unchanged, then return to IDLE.
REQ-014 SHALL, in ACCESS, drive mem_en=1, with mem_addr/mem_we/mem_wdata taken from the latched values; mem_we=0 for IF grants; then go to RESP.
REQ-015 SHALL, in RESP, assert the owner's ack for exactly one cycle, with the owner's rdata equal to mem_rdata (don't-care for stores), then return to IDLE.
REQ-016 SHALL give latency of req sampled in IDLE at edge N -> ack high in cycle N+2, or N+1 for ERR.
REQ-017 SHALL give back-to-back throughput of one access per 3 cycles.
REQ-018 SHALL hold mem_en=0, mem_we=0 and both acks at 0 in every state other than those above; ls_err SHALL be 1 only in ERR.
REQ-019 SHALL rely on the handshake rule that the requester holds req/addr/wdata stable until it samples ack, and that req high in the cycle after ack is a new request.
REQ-020 SHALL not cancel an in-flight access when its req drops after grant; the access completes and acks.
REQ-021 SHALL drive at most one ack per cycle, and never drive both ack outputs together.

Reset
REQ-022 SHALL, on rst=1 at a rising edge, force state IDLE, streak 0, owner IF, and latched addr/wdata to 0.
REQ-023 SHALL hold all outputs 0 during and after reset until a new grant.
REQ-024 SHALL, when reset is asserted in ACCESS, complete at the memory any store sampled on that same edge; no ack SHALL follow.
REQ-025 SHALL, when reset is asserted in RESP or ERR, suppress the ack from the next cycle onward.

Verification
REQ-026 SHALL cover an IF read: if_req=1, if_addr=0x100, mem holds 0xDEADBEEF there -> mem_en=1 at N+1 with addr 0x100, if_ack=1 and if_rdata=0xDEADBEEF at N+2.
REQ-027 SHALL cover a store then load: ls_we=1, ls_addr=0x20, ls_wdata=0x12345678 -> ack at N+2; then a load of 0x20 returns 0x12345678.
REQ-028 SHALL cover a collision: if_req and ls_req both held high continuously, with MAX_LS_STREAK=3 -> grant order LS, LS, LS, IF, LS, ...
REQ-029 SHALL cover misalignment: ls_addr=0x22 -> ls_ack=1 and ls_err=1 at N+1, mem_en never 1.
REQ-030 SHALL cover reset in ACCESS: rst=1 during an IF access -> no if_ack, state IDLE, all outputs 0 the next cycle.
REQ-031 SHALL cover a dropped request: ls_req deasserted the cycle after grant -> ls_ack still pulses at N+2.
